front_panel_loader: RTL and testbench
=====================================

// Module: front_panel_loader
// PURPOSE
//  Hardware sequencer that replaces bench-side button twiddling. It drives the Front_Panel
//  switch/button inputs to copy a stream of (address,data) words into PDP-8 memory.
//  Per word it runs a Load-PC press then a Deposit press. After the last word it loads
//  the start PC, sets the run switch, and reports completion when the CPU halts (run LED falls).
// PARAMETERS
//  HOLD_CYCLES    10        cycles for each phase: switch setup, button high, button low
//  SETTLE_CYCLES  30        idle cycles between the Load-PC op and the Deposit op of a word
//  START_PC       12'o0200  PC loaded before the run switch is set
// PORTS
//  clock        in   1   system clock; single clock domain
//  reset        in   1   asynchronous, active-high reset
//  start        in   1   one-cycle pulse; accepted only in IDLE
//  word_valid   in   1   stream word present
//  word_ready   out  1   loader accepts the word this cycle (valid&&ready = transfer)
//  word_addr    in   12  target memory address
//  word_data    in   12  data to deposit
//  word_last    in   1   final word of the image
//  run_led      in   1   Front_Panel led[12] (CPU running)
//  sw           out  13  Front_Panel sw; [12] = run switch, [11:0] = value switches
//  load_pc_btn  out  1   to Front_Panel btnl
//  deposit_btn  out  1   to Front_Panel btnd
//  busy         out  1   high from start accept until done
//  done         out  1   one-cycle pulse when the run LED falls after run
//  word_count   out  13  words deposited since start (0..4096)
// BEHAVIOUR
//  Reset: sw=0, buttons=0, word_ready=0, busy=0, done=0, word_count=0, FSM=IDLE.
//   Reset mid-operation abandons the sequence immediately; no partial press survives.
//  FSM: IDLE -start-> FETCH -xfer-> LOADPC -op_done-> SETTLE -(SETTLE_CYCLES)-> DEPOSIT
//   -op_done-> (last ? FINAL_PC : FETCH). FINAL_PC -op_done-> RUN_SET (sw[12]=1)
//   -run_led rise-> RUNNING -run_led fall-> DONE (sw[12]=0, done=1 for 1 cycle) -> IDLE.
//  word_ready=1 only in FETCH. Accepting a word latches addr/data/last; ready drops next cycle.
//  Button op (LOADPC/DEPOSIT/FINAL_PC):
//   - op_start cycle: sw[11:0] = value.
//   - Button high during cycles HOLD..2*HOLD-1 after op_start.
//   - Button low afterwards; op_done asserts in cycle 3*HOLD-1.
//   - sw[11:0] holds its value until the next op overwrites it.
//  Only one button is ever high at a time. sw[12]=0 at all times outside RUN_SET/RUNNING.
//  word_count increments in the cycle the deposit button falls; it saturates at 4096.
//  start while busy: ignored. word_valid outside FETCH: not accepted, no effect.
//  Empty image: the first accepted word must carry word_last; zero-word loads are unsupported.
//  run_led already high on RUN_SET entry counts as a rise. Falls are detected edge-wise
//   from a registered copy of run_led.
// CONFIGURATION
//  FPL_AUTOINC_SKIP_EN defined:
//   - Tracks the expected PC (last deposit address+1, 12-bit wrap 7777->0000).
//   - A word whose addr equals the expected PC skips LOADPC and SETTLE (FETCH->DEPOSIT),
//     relying on the Front_Panel deposit auto-increment.
//   - The first word after start always does LOADPC.
//  Undefined: every word does LOADPC, SETTLE, DEPOSIT.
// STRUCTURE
//  Package fpl_pkg:
//   - fpl_state_t enum (IDLE, FETCH, LOADPC, SETTLE, DEPOSIT, FINAL_PC, RUN_SET, RUNNING, DONE)
//   - fpl_btn_t enum (BTN_LOADPC, BTN_DEPOSIT)
//   - RUN_SW_BIT = 12
//  Sub-module fp_button_pulser:
//   - Parameter HOLD_CYCLES.
//   - Inputs op_start, btn_sel, value[11:0]; outputs sw_val, load_pc_btn, deposit_btn, op_done.
//   - Owns its phase counter.
//  Top module contains the FSM, input latch, settle counter, word counter, and autoinc tracker.
// TESTING
//  1 Reset then start; one word {0200, 7402, last}. Expect:
//     - load_pc_btn high cycles 10..19 after op_start, with sw[11:0]=0200.
//     - deposit_btn high with sw=7402.
//     - FINAL_PC loads 0200, then sw[12]=1.
//     - run_led pulse 1->0 produces done=1 for one cycle; word_count=1.
//  2 Three words 0010,0011,0012, then last:
//     - macro off: three load_pc presses.
//     - FPL_AUTOINC_SKIP_EN: one load_pc press; word_count=3 in both.
//  3 word_valid held while a deposit is in flight -> word_ready stays 0; no word is lost or duplicated.
//  4 Assert reset during deposit_btn high -> next cycle all outputs 0, busy=0, state IDLE.
//  5 Words 7777 then 0000 with FPL_AUTOINC_SKIP_EN -> second word skips LOADPC (wrap handled).
//  6 start pulse while busy -> ignored; word_count and sequence unaffected.

Source files
------------

// File: rtl/fpl_pkg.sv
// ============================================================================
// Module   : fpl_pkg
// Purpose  : Shared types and constants for the front-panel image loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpl_pkg;

  // Loader sequencing states
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    LOADPC   = 4'd2,
    SETTLE   = 4'd3,
    DEPOSIT  = 4'd4,
    FINAL_PC = 4'd5,
    RUN_SET  = 4'd6,
    RUNNING  = 4'd7,
    DONE     = 4'd8
  } fpl_state_t;

  // Which front-panel button a press operation drives
  typedef enum logic {
    BTN_LOADPC  = 1'b0,
    BTN_DEPOSIT = 1'b1
  } fpl_btn_t;

  // Position of the run switch within the switch register
  localparam int RUN_SW_BIT = 12;

  // States that own a button press operation
  function automatic logic is_button_state(input fpl_state_t s);
    return (s == LOADPC) || (s == DEPOSIT) || (s == FINAL_PC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_button_pulser.sv
// ============================================================================
// Module   : fp_button_pulser
// Purpose  : Runs one front-panel press: value switches set on op_start,
//            selected button high for HOLD_CYCLES after a HOLD_CYCLES setup,
//            then low for HOLD_CYCLES; op_done in the final cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_button_pulser
  import fpl_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_start,
  input  fpl_btn_t    btn_sel,
  input  logic [11:0] value,
  output logic [11:0] sw_val,
  output logic        load_pc_btn,
  output logic        deposit_btn,
  output logic        op_done
);

  localparam int CW = $clog2(3 * HOLD_CYCLES + 1);
  localparam logic [CW-1:0] C_PRESS_FIRST = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] C_PRESS_LAST  = CW'(2 * HOLD_CYCLES - 1);
  localparam logic [CW-1:0] C_OP_LAST     = CW'(3 * HOLD_CYCLES - 1);

  logic          r_active;
  logic [CW-1:0] r_cnt;     // cycles elapsed since op_start while active
  fpl_btn_t      r_sel;
  logic [11:0]   r_val;
  logic          w_press;

  // Phase counter and latched press parameters; value persists after the op
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_sel    <= BTN_LOADPC;
      r_val    <= '0;
    end else if (op_start) begin
      r_active <= 1'b1;
      r_cnt    <= CW'(1);
      r_sel    <= btn_sel;
      r_val    <= value;
    end else if (r_active) begin
      if (r_cnt == C_OP_LAST) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Switches show the new value already in the op_start cycle
  always_comb begin
    w_press     = r_active && (r_cnt >= C_PRESS_FIRST) && (r_cnt <= C_PRESS_LAST);
    sw_val      = op_start ? value : r_val;
    load_pc_btn = w_press && (r_sel == BTN_LOADPC);
    deposit_btn = w_press && (r_sel == BTN_DEPOSIT);
    op_done     = r_active && (r_cnt == C_OP_LAST);
  end

endmodule

`default_nettype wire

// File: rtl/front_panel_loader.sv
// ============================================================================
// Module   : front_panel_loader
// Purpose  : Copies a stream of (address,data) words into PDP-8 memory by
//            driving front-panel switches/buttons, then loads the start PC,
//            sets RUN and reports completion when the CPU halts.
// Options  : FPL_AUTOINC_SKIP_EN - skip Load-PC when the word address equals
//            the auto-incremented PC left by the previous deposit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module front_panel_loader
  import fpl_pkg::*;
#(
  parameter int          HOLD_CYCLES   = 10,
  parameter int          SETTLE_CYCLES = 30,
  parameter logic [11:0] START_PC      = 12'o0200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [11:0] word_addr,
  input  logic [11:0] word_data,
  input  logic        word_last,
  input  logic        run_led,
  output logic [12:0] sw,
  output logic        load_pc_btn,
  output logic        deposit_btn,
  output logic        busy,
  output logic        done,
  output logic [12:0] word_count
);

  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SCW-1:0] C_SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [12:0]    C_COUNT_MAX   = 13'd4096;

  fpl_state_t     r_state;
  fpl_state_t     w_next;
  logic           r_op_start;
  logic [11:0]    r_addr;
  logic [11:0]    r_data;
  logic           r_last;
  logic [SCW-1:0] r_settle;
  logic           r_run_d;
  logic           r_dep_d;
  logic           w_xfer;
  logic           w_skip;
  logic           w_op_done;
  logic           w_run_sw;
  fpl_btn_t       w_btn_sel;
  logic [11:0]    w_value;
  logic [11:0]    w_sw_val;

  assign w_xfer = (r_state == FETCH) && word_valid;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and per-state outputs
  always_comb begin
    w_next     = r_state;
    word_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    w_run_sw   = 1'b0;
    w_btn_sel  = BTN_LOADPC;
    w_value    = r_addr;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = FETCH;
      end
      FETCH: begin
        word_ready = 1'b1;
        if (word_valid) w_next = w_skip ? DEPOSIT : LOADPC;
      end
      LOADPC: begin
        if (w_op_done) w_next = SETTLE;
      end
      SETTLE: begin
        if (r_settle == C_SETTLE_LAST) w_next = DEPOSIT;
      end
      DEPOSIT: begin
        w_btn_sel = BTN_DEPOSIT;
        w_value   = r_data;
        if (w_op_done) w_next = r_last ? FINAL_PC : FETCH;
      end
      FINAL_PC: begin
        w_value = START_PC;
        if (w_op_done) w_next = RUN_SET;
      end
      RUN_SET: begin
        w_run_sw = 1'b1;
        if (run_led) w_next = RUNNING;
      end
      RUNNING: begin
        w_run_sw = 1'b1;
        if (r_run_d && !run_led) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // One-cycle press request on entry to any button state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_op_start <= 1'b0;
    else       r_op_start <= is_button_state(w_next) && (w_next != r_state);
  end

  // Capture the accepted stream word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (w_xfer) begin
      r_addr <= word_addr;
      r_data <= word_data;
      r_last <= word_last;
    end
  end

  // Idle time between Load-PC and Deposit of a word
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  r_settle <= '0;
    else if (r_state == SETTLE) r_settle <= r_settle + SCW'(1);
    else                        r_settle <= '0;
  end

  // Registered copies for edge detection of run LED and deposit button
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run_d <= 1'b0;
      r_dep_d <= 1'b0;
    end else begin
      r_run_d <= run_led;
      r_dep_d <= deposit_btn;
    end
  end

  // Deposited-word counter, cleared on start, saturating
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_count <= '0;
    end else if ((r_state == IDLE) && start) begin
      word_count <= '0;
    end else if (r_dep_d && !deposit_btn && (word_count != C_COUNT_MAX)) begin
      word_count <= word_count + 13'd1;
    end
  end

`ifdef FPL_AUTOINC_SKIP_EN
  logic [11:0] r_exp_pc;
  logic        r_exp_valid;

  // PC the panel holds after a deposit; forgotten at each start
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_exp_pc    <= '0;
      r_exp_valid <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_exp_valid <= 1'b0;
    end else if ((r_state == DEPOSIT) && w_op_done) begin
      r_exp_pc    <= r_addr + 12'd1;
      r_exp_valid <= 1'b1;
    end
  end

  assign w_skip = r_exp_valid && (word_addr == r_exp_pc);
`else
  assign w_skip = 1'b0;
`endif

  fp_button_pulser #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_pulser (
    .clock       (clock),
    .reset       (reset),
    .op_start    (r_op_start),
    .btn_sel     (w_btn_sel),
    .value       (w_value),
    .sw_val      (w_sw_val),
    .load_pc_btn (load_pc_btn),
    .deposit_btn (deposit_btn),
    .op_done     (w_op_done)
  );

  // Run switch lives above the value switches
  always_comb begin
    sw                   = '0;
    sw[RUN_SW_BIT]       = w_run_sw;
    sw[RUN_SW_BIT-1:0]   = w_sw_val;
  end

endmodule

`default_nettype wire

// File: tb/tb_front_panel_loader.sv
// ============================================================================
// Module   : tb_front_panel_loader
// Purpose  : Table-driven bench for front_panel_loader: word images with
//            hand-computed press sequences, plus reset/start corner cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_front_panel_loader;

  localparam int          HOLD   = 10;
  localparam int          SETTLE = 30;
  localparam logic [11:0] SPC    = 12'o0200;
`ifdef FPL_AUTOINC_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [11:0] word_addr = '0;
  logic [11:0] word_data = '0;
  logic        word_last = 1'b0;
  logic        run_led = 1'b0;
  logic [12:0] sw;
  logic        load_pc_btn;
  logic        deposit_btn;
  logic        busy;
  logic        done;
  logic [12:0] word_count;

  front_panel_loader #(
    .HOLD_CYCLES   (HOLD),
    .SETTLE_CYCLES (SETTLE),
    .START_PC      (SPC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_addr   (word_addr),
    .word_data   (word_data),
    .word_last   (word_last),
    .run_led     (run_led),
    .sw          (sw),
    .load_pc_btn (load_pc_btn),
    .deposit_btn (deposit_btn),
    .busy        (busy),
    .done        (done),
    .word_count  (word_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic [11:0] lp_got[$];
  logic [11:0] dp_got[$];
  logic [11:0] press_sw;
  int viol = 0, done_cnt = 0, hs_cnt = 0;
  int rise_cyc = 0, hs0 = 0, lpr0 = 0, lpf0 = 0, dpr0 = 0;
  bit have_hs, have_lpr, have_lpf, have_dpr;
  logic p_lp = 0, p_dp = 0, p_done = 0;

  always @(negedge clock) begin
    if (reset) begin
      p_lp = 0; p_dp = 0; p_done = 0;
    end else begin
      if (load_pc_btn && !p_lp) begin
        lp_got.push_back(sw[11:0]); press_sw = sw[11:0]; rise_cyc = cyc;
        if (!have_lpr) begin have_lpr = 1; lpr0 = cyc; end
      end
      if (!load_pc_btn && p_lp) begin
        if (cyc - rise_cyc != HOLD) viol++;
        if (!have_lpf) begin have_lpf = 1; lpf0 = cyc; end
      end
      if (deposit_btn && !p_dp) begin
        dp_got.push_back(sw[11:0]); press_sw = sw[11:0]; rise_cyc = cyc;
        if (!have_dpr) begin have_dpr = 1; dpr0 = cyc; end
      end
      if (!deposit_btn && p_dp && (cyc - rise_cyc != HOLD)) viol++;
      if ((load_pc_btn || deposit_btn) && sw[11:0] != press_sw) viol++;
      if (load_pc_btn && deposit_btn) viol++;
      if (sw[12] && (load_pc_btn || deposit_btn || word_ready)) viol++;
      if (word_ready && (load_pc_btn || deposit_btn)) viol++;
      if (done) begin done_cnt++; if (p_done) viol++; end
      p_lp = load_pc_btn; p_dp = deposit_btn; p_done = done;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int          img;
    logic [11:0] addr;
    logic [11:0] data;
    logic        last;
    logic        lp;    // a Load-PC press precedes this word's deposit
  } vec_t;

  localparam int NV = 10;
  vec_t tbl[NV];

  // ---------------- drivers ----------------
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [11:0] a, input logic [11:0] d, input logic l, output bit ok);
    word_addr = a; word_data = d; word_last = l; word_valid = 1'b1; ok = 0;
    for (int n = 0; n < 2000; n++) begin
      if (word_ready) begin
        hs_cnt++;
        if (!have_hs) begin have_hs = 1; hs0 = cyc; end
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    if (l || !ok) word_valid = 1'b0;
  endtask

  task automatic clear_mon();
    lp_got.delete(); dp_got.delete();
    done_cnt = 0; hs_cnt = 0;
    have_hs = 0; have_lpr = 0; have_lpf = 0; have_dpr = 0;
  endtask

  task automatic run_img(input int img, input bit poke_start, input bit timing);
    logic [11:0] exp_lp[$];
    logic [11:0] exp_dp[$];
    int nw = 0;
    bit ok;
    bit first = 1;
    clear_mon();
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].img == img) begin
        nw++;
        if (tbl[i].lp) exp_lp.push_back(tbl[i].addr);
        exp_dp.push_back(tbl[i].data);
      end
    end
    exp_lp.push_back(SPC);

    pulse_start();
    chk($sformatf("img%0d busy", img), busy, 1);
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].img == img) begin
        send_word(tbl[i].addr, tbl[i].data, tbl[i].last, ok);
        chk($sformatf("img%0d xfer%0d", img, i), ok, 1);
        if (!ok) return;
        if (first && poke_start) pulse_start();
        first = 0;
      end
    end

    for (int n = 0; n < 3000 && !sw[12]; n++) tick();
    chk($sformatf("img%0d run_sw", img), sw[12], 1);
    repeat (3) tick();
    chk($sformatf("img%0d early_done", img), done_cnt, 0);
    run_led = 1'b1;
    repeat (5) tick();
    chk($sformatf("img%0d running_sw", img), sw[12], 1);
    run_led = 1'b0;
    for (int n = 0; n < 20 && done_cnt == 0; n++) tick();
    repeat (2) tick();
    chk($sformatf("img%0d done_cnt", img), done_cnt, 1);
    chk($sformatf("img%0d busy_end", img), busy, 0);
    chk($sformatf("img%0d sw_end", img), sw, {1'b0, SPC});
    chk($sformatf("img%0d word_count", img), word_count, nw);
    chk($sformatf("img%0d handshakes", img), hs_cnt, nw);
    chk($sformatf("img%0d lp_n", img), lp_got.size(), exp_lp.size());
    chk($sformatf("img%0d dp_n", img), dp_got.size(), exp_dp.size());
    for (int k = 0; k < exp_lp.size() && k < lp_got.size(); k++)
      chk($sformatf("img%0d lp_sw%0d", img, k), lp_got[k], exp_lp[k]);
    for (int k = 0; k < exp_dp.size() && k < dp_got.size(); k++)
      chk($sformatf("img%0d dp_sw%0d", img, k), dp_got[k], exp_dp[k]);
    if (timing) begin
      chk("lp_rise_latency", lpr0 - hs0, HOLD + 1);
      chk("lp_fall_to_dp_rise", dpr0 - lpf0, 2 * HOLD + SETTLE);
    end
    chk($sformatf("img%0d invariants", img), viol, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    tbl[0] = '{0, 12'o0200, 12'o7402, 1'b1, 1'b1};
    tbl[1] = '{1, 12'o0010, 12'o1234, 1'b0, 1'b1};
    tbl[2] = '{1, 12'o0011, 12'o2345, 1'b0, !SKIP};
    tbl[3] = '{1, 12'o0012, 12'o3456, 1'b1, !SKIP};
    tbl[4] = '{2, 12'o7777, 12'o0001, 1'b0, 1'b1};
    tbl[5] = '{2, 12'o0000, 12'o0002, 1'b1, !SKIP};
    tbl[6] = '{3, 12'o0100, 12'o1111, 1'b0, 1'b1};
    tbl[7] = '{3, 12'o0300, 12'o2222, 1'b1, 1'b1};
    tbl[8] = '{4, 12'o0301, 12'o4444, 1'b1, 1'b1};
    tbl[9] = '{5, 12'o0000, 12'o0000, 1'b1, 1'b1};

    // reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst sw", sw, 0);
    chk("rst load_pc", load_pc_btn, 0);
    chk("rst deposit", deposit_btn, 0);
    chk("rst ready", word_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst count", word_count, 0);

    // word_valid in IDLE is not accepted
    word_valid = 1'b1;
    tick();
    chk("idle ready", word_ready, 0);
    tick();
    chk("idle busy", busy, 0);
    word_valid = 1'b0;

    run_img(0, 0, 1);   // single word with press timing
    run_img(1, 0, 0);   // sequential words, valid held back-to-back
    run_img(2, 0, 0);   // 7777 -> 0000 wrap
    run_img(3, 1, 0);   // non-sequential, start pulse while busy
    run_img(4, 0, 0);   // first word after start always loads PC

    // reset while the deposit button is high
    clear_mon();
    pulse_start();
    send_word(12'o0400, 12'o5555, 1'b1, ok);
    chk("rstmid xfer", ok, 1);
    for (int n = 0; n < 500 && !deposit_btn; n++) tick();
    chk("rstmid dep_high", deposit_btn, 1);
    reset = 1'b1;
    #1;
    chk("rstmid sw", sw, 0);
    chk("rstmid load_pc", load_pc_btn, 0);
    chk("rstmid deposit", deposit_btn, 0);
    chk("rstmid ready", word_ready, 0);
    chk("rstmid busy", busy, 0);
    chk("rstmid done", done, 0);
    chk("rstmid count", word_count, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    chk("rstmid idle_busy", busy, 0);
    chk("rstmid idle_sw", sw, 0);

    run_img(0, 0, 0);   // recovers cleanly after abort

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
